// File: rtl/multicycle_core.sv
// RV32I/E subset multicycle core (FETCH/DECODE/EXECUTE/WRITEBACK), 4+ cycles per instruction.
// Optional BRANCH support under macro CORE_BRANCH_EN; fetch stalls while imem_ready is low.
module multicycle_core #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              retire,
  output logic              err,
  output logic [31:0]       dbg_pc,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data
);

  localparam int RW = (NUM_REGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
`ifdef CORE_BRANCH_EN
  localparam logic [6:0] OPC_BR    = 7'b1100011;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, ERROR} state_t;

  state_t      state;
  logic [31:0] pc, instr, rs1_val, rs2_val, result, next_pc;
  logic        wr_en;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef CORE_BRANCH_EN
  logic [31:0] imm_b;
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
`endif

  assign imem_addr = pc[ADDR_W-1:0];
  assign dbg_pc    = pc;

  function automatic logic reg_ok(input logic [4:0] idx);
    return (NUM_REGS == 32) || !idx[4];
  endfunction

  assign dbg_data = reg_ok(dbg_sel) ? regs[dbg_sel[RW-1:0]] : 32'd0;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    case (op)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, $signed(a) < $signed(b)};
      3'b011:  return {31'd0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  logic illegal;
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_OP:
        illegal = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                  || !reg_ok(rd) || !reg_ok(rs1) || !reg_ok(rs2);
      OPC_IMM: begin
        if (f3 == 3'b001)
          illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        illegal = illegal || !reg_ok(rd) || !reg_ok(rs1);
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL:
        illegal = !reg_ok(rd);
      OPC_JALR:
        illegal = (f3 != 3'b000) || !reg_ok(rd) || !reg_ok(rs1);
`ifdef CORE_BRANCH_EN
      OPC_BR:
        illegal = (f3 == 3'b010) || (f3 == 3'b011) || !reg_ok(rs1) || !reg_ok(rs2);
`endif
      default:
        illegal = 1'b1;
    endcase
  end

  logic [31:0] ex_res, ex_npc;
  logic        ex_wr, ex_jump, misalign;
  always_comb begin
    ex_res  = 32'd0;
    ex_npc  = pc + 32'd4;
    ex_wr   = 1'b0;
    ex_jump = 1'b0;
    case (opcode)
      OPC_OP:    begin ex_res = alu(rs1_val, rs2_val, f3, f7[5]); ex_wr = 1'b1; end
      OPC_IMM:   begin ex_res = alu(rs1_val, imm_i, f3, (f3 == 3'b101) && f7[5]); ex_wr = 1'b1; end
      OPC_LUI:   begin ex_res = imm_u; ex_wr = 1'b1; end
      OPC_AUIPC: begin ex_res = pc + imm_u; ex_wr = 1'b1; end
      OPC_JAL:   begin ex_res = pc + 32'd4; ex_wr = 1'b1; ex_npc = pc + imm_j; ex_jump = 1'b1; end
      OPC_JALR:  begin
        ex_res  = pc + 32'd4;
        ex_wr   = 1'b1;
        ex_npc  = (rs1_val + imm_i) & ~32'd1;
        ex_jump = 1'b1;
      end
`ifdef CORE_BRANCH_EN
      OPC_BR: begin
        case (f3)
          3'b000:  ex_jump = (rs1_val == rs2_val);
          3'b001:  ex_jump = (rs1_val != rs2_val);
          3'b100:  ex_jump = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  ex_jump = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  ex_jump = (rs1_val <  rs2_val);
          3'b111:  ex_jump = (rs1_val >= rs2_val);
          default: ex_jump = 1'b0;
        endcase
        if (ex_jump) ex_npc = pc + imm_b;
      end
`endif
      default: ;
    endcase
    // Only a redirect can produce a misaligned target; fall-through is always pc+4.
    misalign = ex_jump && (ex_npc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      err      <= 1'b0;
      retire   <= 1'b0;
      imem_req <= 1'b0;
      instr    <= 32'd0;
      rs1_val  <= 32'd0;
      rs2_val  <= 32'd0;
      result   <= 32'd0;
      next_pc  <= 32'd0;
      wr_en    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          // The first cycle out of reset raises the request; data is only taken while it is up.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (illegal) begin
            err   <= 1'b1;
            state <= ERROR;
          end else begin
            rs1_val <= regs[rs1[RW-1:0]];
            rs2_val <= regs[rs2[RW-1:0]];
            state   <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (misalign) begin
            err   <= 1'b1;
            state <= ERROR;
          end else begin
            result  <= ex_res;
            next_pc <= ex_npc;
            wr_en   <= ex_wr;
            retire  <= 1'b1;
            state   <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          pc       <= next_pc;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        ERROR:   imem_req <= 1'b0;
        default: state <= ERROR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (state == WRITEBACK && wr_en && rd != 5'd0) begin
      regs[rd[RW-1:0]] <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: table of short programs plus stall/reset and RV32E sequences.
module tb_multicycle_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_ready, retire, err;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata, dbg_pc, dbg_data;
  logic [4:0]  dbg_sel;

  logic        imem_req2, imem_ready2, retire2, err2;
  logic [15:0] imem_addr2;
  logic [31:0] imem_rdata2, dbg_pc2, dbg_data2;
  logic [4:0]  dbg_sel2;

  logic [31:0] mem [16];
  logic [13:0] prog_len;
  logic        ready_en;

  // Words past the end of the loaded program are never acknowledged, so the core parks in FETCH.
  assign imem_ready  = ready_en && (imem_addr[15:2] < prog_len);
  assign imem_rdata  = mem[imem_addr[5:2]];
  assign imem_ready2 = (imem_addr2[15:2] < 14'd2);
  assign imem_rdata2 = imem_addr2[2] ? 32'h01000813 : 32'h00300093;

  multicycle_core dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .retire(retire), .err(err),
    .dbg_pc(dbg_pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  multicycle_core #(.NUM_REGS(16)) dut_e (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2), .retire(retire2), .err(err2),
    .dbg_pc(dbg_pc2), .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
  );

  int rcnt;
  always @(posedge clk) begin
    if (rst) rcnt <= 0;
    else if (retire) rcnt <= rcnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2;
    logic [13:0] len;
    logic [4:0]  sel;
    logic [31:0] val;
    logic [31:0] pc;
    logic        err;
    int          ret;
  } vec_t;

  vec_t vecs [16];

  task automatic set_vec(input int i, input string n, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [13:0] len, input logic [4:0] sel,
                         input logic [31:0] val, input logic [31:0] pc, input logic e, input int ret);
    vecs[i].name = n;   vecs[i].w0 = w0;   vecs[i].w1 = w1;   vecs[i].w2 = w2;
    vecs[i].len  = len; vecs[i].sel = sel; vecs[i].val = val; vecs[i].pc = pc;
    vecs[i].err  = e;   vecs[i].ret = ret;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) mem[k] = 32'd0;
    mem[0] = v.w0; mem[1] = v.w1; mem[2] = v.w2;
    prog_len = v.len;
    ready_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    dbg_sel = v.sel;
    #1;
    check({v.name, " reg"},    dbg_data, v.val);
    check({v.name, " pc"},     dbg_pc, v.pc);
    check({v.name, " err"},    {31'd0, err}, {31'd0, v.err});
    check({v.name, " retire"}, rcnt, v.ret);
    check({v.name, " req"},    {31'd0, imem_req}, {31'd0, !v.err});
  endtask

  initial begin
    rst = 1'b1; ready_en = 1'b0; prog_len = 14'd0; dbg_sel = 5'd0; dbg_sel2 = 5'd0;
    for (int k = 0; k < 16; k++) mem[k] = 32'd0;

    set_vec(0,  "add",     32'h00500093, 32'h00700113, 32'h002081B3, 3, 3, 32'd12,        32'd12, 0, 3);
    set_vec(1,  "sub",     32'h00500093, 32'h00700113, 32'h402081B3, 3, 3, 32'hFFFFFFFE,  32'd12, 0, 3);
    set_vec(2,  "slt",     32'h00500093, 32'h00700113, 32'h0020A1B3, 3, 3, 32'd1,         32'd12, 0, 3);
    set_vec(3,  "sltu",    32'hFFF00093, 32'h00100113, 32'h001131B3, 3, 3, 32'd1,         32'd12, 0, 3);
    set_vec(4,  "jal",     32'h008000EF, 32'd0,        32'd0,        1, 1, 32'd4,         32'd8,  0, 1);
    set_vec(5,  "lui",     32'h123452B7, 32'd0,        32'd0,        1, 5, 32'h12345000,  32'd4,  0, 1);
    set_vec(6,  "srli",    32'hFFF00093, 32'h0040D113, 32'd0,        2, 2, 32'h0FFFFFFF,  32'd8,  0, 2);
    set_vec(7,  "srai",    32'hFFF00093, 32'h4040D113, 32'd0,        2, 2, 32'hFFFFFFFF,  32'd8,  0, 2);
    set_vec(8,  "auipc",   32'h00500093, 32'h00001217, 32'd0,        2, 4, 32'h00001004,  32'd8,  0, 2);
    set_vec(9,  "x0",      32'h00500013, 32'd0,        32'd0,        1, 0, 32'd0,         32'd4,  0, 1);
    set_vec(10, "badop",   32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 32'd0,         32'd0,  1, 0);
    set_vec(11, "badf7",   32'h4020C1B3, 32'd0,        32'd0,        1, 3, 32'd0,         32'd0,  1, 0);
`ifdef CORE_BRANCH_EN
    set_vec(12, "beq",     32'h00000463, 32'd0,        32'd0,        1, 0, 32'd0,         32'd8,  0, 1);
`else
    set_vec(12, "beq",     32'h00000463, 32'd0,        32'd0,        1, 0, 32'd0,         32'd0,  1, 0);
`endif
    set_vec(13, "jalrmis", 32'h00200093, 32'h000082E7, 32'd0,        2, 5, 32'd0,         32'd4,  1, 1);
    set_vec(14, "jalr",    32'h00300093, 32'h005082E7, 32'd0,        2, 5, 32'd8,         32'd8,  0, 2);
    set_vec(15, "sll33",   32'h00300093, 32'h02100113, 32'h002091B3, 3, 3, 32'd6,         32'd12, 0, 3);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset state, then a long fetch stall, then a reset while parked in FETCH.
    @(negedge clk);
    rst = 1'b1; ready_en = 1'b0; prog_len = 14'd1;
    for (int k = 0; k < 16; k++) mem[k] = 32'd0;
    mem[0] = 32'h00500093;
    repeat (2) @(negedge clk);
    dbg_sel = 5'd1;
    #1;
    check("rst req",    {31'd0, imem_req}, 32'd0);
    check("rst err",    {31'd0, err}, 32'd0);
    check("rst retire", {31'd0, retire}, 32'd0);
    check("rst pc",     dbg_pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("stall req",    {31'd0, imem_req}, 32'd1);
      check("stall addr",   {16'd0, imem_addr}, 32'd0);
      check("stall retire", rcnt, 32'd0);
      @(negedge clk);
    end
    ready_en = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("post-stall x1",  dbg_data, 32'd5);
    check("post-stall ret", rcnt, 32'd1);
    check("post-stall pc",  dbg_pc, 32'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst req", {31'd0, imem_req}, 32'd0);
    check("midrst pc",  dbg_pc, 32'd0);
    check("midrst x1",  dbg_data, 32'd0);
    rst = 1'b0; ready_en = 1'b0;
    @(negedge clk);
    check("rel req", {31'd0, imem_req}, 32'd1);
    check("rel pc",  dbg_pc, 32'd0);

    // RV32E instance has been running its two-word program since the last reset.
    repeat (20) @(negedge clk);
    dbg_sel2 = 5'd1;
    #1;
    check("e err",  {31'd0, err2}, 32'd1);
    check("e pc",   dbg_pc2, 32'd4);
    check("e req",  {31'd0, imem_req2}, 32'd0);
    check("e x1",   dbg_data2, 32'd3);
    dbg_sel2 = 5'd16;
    #1;
    check("e x16",  dbg_data2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
